// File: rtl/serial_subi.sv
// rtl/serial_subi.sv - bit-serial unsigned subtractor, out = sum - in2 mod 2^W, LSB first.
module serial_subi #(
    parameter int msb = 4,
    parameter int lsb = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [msb:lsb] sum,
    input  logic [msb:lsb] in2,
    output logic           busy,
    output logic           done,
    output logic [msb:lsb] out,
    output logic           borrow
);
    localparam int W  = msb - lsb + 1;
    localparam int CW = ($clog2(W + 1) < 1) ? 1 : $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nx;
    logic [msb:lsb] a_sh, b_sh, res_sh;
    logic [msb:lsb] a_nx, b_nx, res_nx, out_nx;
    logic           brw, brw_nx, borrow_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           d, bit_brw, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            borrow <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sh   <= a_nx;
            b_sh   <= b_nx;
            res_sh <= res_nx;
            brw    <= brw_nx;
            cnt    <= cnt_nx;
            out    <= out_nx;
            borrow <= borrow_nx;
        end
    end

    always_comb begin
        d         = a_sh[lsb] ^ b_sh[lsb] ^ brw;
        bit_brw   = (~a_sh[lsb] & b_sh[lsb]) | (~(a_sh[lsb] ^ b_sh[lsb]) & brw);
        last      = (cnt == CW'(W - 1));
        state_nx  = state;
        a_nx      = a_sh;
        b_nx      = b_sh;
        res_nx    = res_sh;
        brw_nx    = brw;
        cnt_nx    = cnt;
        out_nx    = out;
        borrow_nx = borrow;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nx     = sum;
                    b_nx     = in2;
                    brw_nx   = 1'b0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so after W shifts bit lsb holds the first difference bit.
                res_nx      = res_sh >> 1;
                res_nx[msb] = d;
                a_nx        = a_sh >> 1;
                b_nx        = b_sh >> 1;
                brw_nx      = bit_brw;
                cnt_nx      = cnt + 1'b1;
                if (last) begin
                    out_nx    = res_nx;
                    borrow_nx = bit_brw;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule
